ball_collision: RTL and testbench
=================================

BALL_COLLISION -- requirements
Module: ball_collision

Interface
REQ-001 SHALL have parameter p_MISS_FRAMES, default 60, frames the ball stays frozen after a miss (1..255).
REQ-002 SHALL have port i_Clk  input  1  pixel clock, all logic on rising edge.
REQ-003 SHALL have port i_Reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port i_HReset  input  1  last pixel of a line (timing generator).
REQ-005 SHALL have port i_VReset  input  1  last line of a frame; frame end = i_HReset && i_VReset.
REQ-006 SHALL have port i_HBlank  input  1  horizontal blanking active.
REQ-007 SHALL have port i_VBlank  input  1  vertical blanking active.
REQ-008 SHALL have port i_Ball  input  1  ball video (horizontal AND vertical component).
REQ-009 SHALL have port i_PaddleL  input  1  left paddle video.
REQ-010 SHALL have port i_PaddleR  input  1  right paddle video.
REQ-011 SHALL have port o_HDir  output  1  1 = ball moves left (toward column 0), 0 = right; drives the horizontal ball counter's direction input.
REQ-012 SHALL have port o_VDir  output  1  1 = ball moves up, 0 = down.
REQ-013 SHALL have port o_ScoreL  output  1  one-cycle pulse, left player scores.
REQ-014 SHALL have port o_ScoreR  output  1  one-cycle pulse, right player scores.
REQ-015 SHALL have port o_Freeze  output  1  1 = ball motion suppressed (MISS state).

Function
REQ-016 SHALL sample inputs only while ~i_HBlank && ~i_VBlank (visible area); all outputs registered.
REQ-017 SHALL set latch hitL when i_Ball && i_PaddleL in a visible pixel; likewise hitR with i_PaddleR.
REQ-018 SHALL set latch edgeL when i_Ball is 1 on the first visible pixel of any line (first cycle after i_HBlank falls).
REQ-019 SHALL set latch edgeR when the registered i_Ball of the last visible pixel is 1 at the i_HBlank rising edge.
REQ-020 SHALL keep a per-line flag (i_Ball seen this line); edgeT set if flag is 1 at end of first visible line after i_VBlank falls; edgeB set if flag is 1 at i_VBlank rising edge.
REQ-021 SHALL evaluate latches once per frame at frame end, then clear all latches in the same cycle; events occurring on that cycle are lost (not carried over).
REQ-022 SHALL implement states SERVE, PLAY, MISS; encoding free.
REQ-023 In PLAY at frame end: hitL && ~hitR -> o_HDir<=0; hitR && ~hitL -> o_HDir<=1; both -> o_HDir unchanged.
REQ-024 In PLAY at frame end: edgeL && ~hitL -> o_ScoreR pulse, o_HDir<=0, state MISS; edgeR && ~hitR -> o_ScoreL pulse, o_HDir<=1, state MISS; both edges -> no score, o_HDir unchanged, stay PLAY.
REQ-025 In PLAY at frame end: edgeT && ~edgeB -> o_VDir<=0; edgeB && ~edgeT -> o_VDir<=1; both -> unchanged; vertical rules apply alongside REQ-023/024.
REQ-026 Score pulses SHALL be exactly one i_Clk cycle, asserted the cycle after the frame-end cycle; never both in the same cycle.
REQ-027 MISS SHALL load an 8-bit frame counter with p_MISS_FRAMES, decrement at each frame end, assert o_Freeze throughout, and go to SERVE at frame end when counter is 1.
REQ-028 SERVE SHALL last exactly one frame (o_Freeze=0, latches ignored), then PLAY at the next frame end.
REQ-029 In SERVE and MISS, latches SHALL be held clear and no direction or score change occurs.

Reset
REQ-030 i_Reset SHALL, in the same cycle it is sampled, force state SERVE, o_HDir=0, o_VDir=0, o_ScoreL=0, o_ScoreR=0, o_Freeze=0, counter 0, all latches and the line flag 0; it overrides a coincident frame end.
REQ-031 Reset asserted mid-frame or mid-MISS SHALL abort any pending event; no score pulse is emitted afterwards for that frame.

Verification
REQ-032 Reset, one frame -> SERVE, then PLAY; all outputs 0 throughout.
REQ-033 PLAY, o_HDir=1, i_Ball&&i_PaddleL on line 200 -> at frame end o_HDir=0, no score pulse.
REQ-034 PLAY, o_HDir=1, i_Ball on first pixel of line 240, no paddle overlap -> o_ScoreR one-cycle pulse, o_HDir=0, o_Freeze=1 for exactly 60 frames, then one SERVE frame, then PLAY.
REQ-035 PLAY, ball visible on last visible line before i_VBlank -> o_VDir=1 at frame end; ball on first visible line -> o_VDir=0.
REQ-036 Ball touching left edge and left paddle same frame -> o_HDir=0, no score; i_Reset asserted at the frame-end cycle of a miss frame -> no o_ScoreR pulse, state SERVE.

Source files
------------

// File: rtl/ball_collision.sv
// Purpose : Pong ball collision/score controller; sees ball and paddle video once per pixel
//           and decides ball direction, scoring and the post-miss freeze once per frame.
// Latency : outputs are registered and update one cycle after the frame-end pixel.
//           Score pulses are one cycle wide.
// Backpressure: none. The block follows the video timing generator every cycle.
// Ports   : i_Clk/i_Reset         pixel clock, synchronous active-high reset
//           i_HReset/i_VReset     last pixel of the line / last line of the frame
//           i_HBlank/i_VBlank     blanking flags; only visible pixels are examined
//           i_Ball/i_PaddleL/R    object video
//           o_HDir/o_VDir         ball direction (1 = left / up)
//           o_ScoreL/o_ScoreR     score pulses
//           o_Freeze              ball motion suppressed while a miss is shown
module ball_collision #(
    parameter int unsigned p_MISS_FRAMES = 60
) (
    input  logic i_Clk,
    input  logic i_Reset,
    input  logic i_HReset,
    input  logic i_VReset,
    input  logic i_HBlank,
    input  logic i_VBlank,
    input  logic i_Ball,
    input  logic i_PaddleL,
    input  logic i_PaddleR,
    output logic o_HDir,
    output logic o_VDir,
    output logic o_ScoreL,
    output logic o_ScoreR,
    output logic o_Freeze
);

    typedef enum logic [1:0] {
        ST_SERVE = 2'd0,
        ST_PLAY  = 2'd1,
        ST_MISS  = 2'd2
    } state_t;

    state_t     state, state_nxt;
    logic       hblank_d, vblank_d, ball_d;
    logic       line_flag, first_line;
    logic       hit_l, hit_r, edge_l, edge_r, edge_t, edge_b;
    logic [7:0] miss_cnt, miss_cnt_nxt;
    logic       hdir_nxt, vdir_nxt, score_l_nxt, score_r_nxt;
    logic       visible, frame_end, line_start, line_end, vblank_rise, vblank_fall;
    logic       miss_l, miss_r;

    assign visible     = ~i_HBlank & ~i_VBlank;
    assign frame_end   = i_HReset & i_VReset;
    // First visible pixel of a line: horizontal blanking just ended inside the active field.
    assign line_start  = hblank_d & ~i_HBlank & ~i_VBlank;
    // Horizontal blanking just started. The last visible pixel is in ball_d.
    assign line_end    = ~hblank_d & i_HBlank;
    assign vblank_rise = ~vblank_d & i_VBlank;
    assign vblank_fall = vblank_d & ~i_VBlank;

    // Blanking history keeps tracking during reset, so the first line after reset is
    // recognised correctly.
    always_ff @(posedge i_Clk) begin
        hblank_d <= i_HBlank;
        vblank_d <= i_VBlank;
    end

    // Line bookkeeping. line_flag is restarted on the first visible pixel, not at
    // i_HReset, so it still holds the last visible line when vertical blanking starts.
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            ball_d     <= 1'b0;
            line_flag  <= 1'b0;
            first_line <= 1'b0;
        end else begin
            ball_d <= visible & i_Ball;
            if (line_start)
                line_flag <= i_Ball;
            else if (visible && i_Ball)
                line_flag <= 1'b1;
            if (vblank_fall)
                first_line <= 1'b1;
            else if (line_end)
                first_line <= 1'b0;
        end
    end

    // Per-frame event latches. They collect only in PLAY and are wiped at every frame end.
    always_ff @(posedge i_Clk) begin
        if (i_Reset || frame_end || state != ST_PLAY) begin
            hit_l  <= 1'b0;
            hit_r  <= 1'b0;
            edge_l <= 1'b0;
            edge_r <= 1'b0;
            edge_t <= 1'b0;
            edge_b <= 1'b0;
        end else begin
            if (visible && i_Ball && i_PaddleL)      hit_l  <= 1'b1;
            if (visible && i_Ball && i_PaddleR)      hit_r  <= 1'b1;
            if (line_start && i_Ball)                edge_l <= 1'b1;
            if (line_end && ball_d)                  edge_r <= 1'b1;
            if (line_end && first_line && line_flag) edge_t <= 1'b1;
            if (vblank_rise && line_flag)            edge_b <= 1'b1;
        end
    end

    // A paddle hit on a side cancels the miss on that side.
    assign miss_l = edge_l & ~hit_l;
    assign miss_r = edge_r & ~hit_r;

    always_comb begin
        state_nxt    = state;
        hdir_nxt     = o_HDir;
        vdir_nxt     = o_VDir;
        score_l_nxt  = 1'b0;
        score_r_nxt  = 1'b0;
        miss_cnt_nxt = miss_cnt;
        if (frame_end) begin
            case (state)
                ST_SERVE: state_nxt = ST_PLAY;
                ST_PLAY: begin
                    if (hit_l && !hit_r)
                        hdir_nxt = 1'b0;
                    else if (hit_r && !hit_l)
                        hdir_nxt = 1'b1;
                    if (edge_t && !edge_b)
                        vdir_nxt = 1'b0;
                    else if (edge_b && !edge_t)
                        vdir_nxt = 1'b1;
                    // A miss on both sides in one frame is ambiguous, so play continues.
                    if (miss_l && !miss_r) begin
                        score_r_nxt  = 1'b1;
                        hdir_nxt     = 1'b0;
                        state_nxt    = ST_MISS;
                        miss_cnt_nxt = 8'(p_MISS_FRAMES);
                    end else if (miss_r && !miss_l) begin
                        score_l_nxt  = 1'b1;
                        hdir_nxt     = 1'b1;
                        state_nxt    = ST_MISS;
                        miss_cnt_nxt = 8'(p_MISS_FRAMES);
                    end
                end
                ST_MISS: begin
                    if (miss_cnt <= 8'd1) begin
                        state_nxt    = ST_SERVE;
                        miss_cnt_nxt = 8'd0;
                    end else begin
                        miss_cnt_nxt = miss_cnt - 8'd1;
                    end
                end
                default: state_nxt = ST_SERVE;
            endcase
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state    <= ST_SERVE;
            miss_cnt <= 8'd0;
            o_HDir   <= 1'b0;
            o_VDir   <= 1'b0;
            o_ScoreL <= 1'b0;
            o_ScoreR <= 1'b0;
            o_Freeze <= 1'b0;
        end else begin
            state    <= state_nxt;
            miss_cnt <= miss_cnt_nxt;
            o_HDir   <= hdir_nxt;
            o_VDir   <= vdir_nxt;
            o_ScoreL <= score_l_nxt;
            o_ScoreR <= score_r_nxt;
            o_Freeze <= (state_nxt == ST_MISS);
        end
    end

endmodule

// File: tb/tb_ball_collision.sv
// Testbench for ball_collision on a miniature raster: 8x6 pixels total, with a
// 6x4 visible area. Each frame is described as a picture (ball rectangle plus paddles).
// The frame flags and expected outputs are derived from that picture.
module tb_ball_collision;

    localparam int HT = 8;
    localparam int HV = 6;
    localparam int VT = 6;
    localparam int VV = 4;
    localparam int S_SERVE = 0;
    localparam int S_PLAY  = 1;
    localparam int S_MISS  = 2;
    localparam int MISS_FRAMES = 60;

    logic i_Clk, i_Reset, i_HReset, i_VReset, i_HBlank, i_VBlank;
    logic i_Ball, i_PaddleL, i_PaddleR;
    logic o_HDir, o_VDir, o_ScoreL, o_ScoreR, o_Freeze;

    ball_collision dut (
        .i_Clk(i_Clk), .i_Reset(i_Reset), .i_HReset(i_HReset), .i_VReset(i_VReset),
        .i_HBlank(i_HBlank), .i_VBlank(i_VBlank), .i_Ball(i_Ball),
        .i_PaddleL(i_PaddleL), .i_PaddleR(i_PaddleR),
        .o_HDir(o_HDir), .o_VDir(o_VDir), .o_ScoreL(o_ScoreL), .o_ScoreR(o_ScoreR),
        .o_Freeze(o_Freeze)
    );

    initial i_Clk = 1'b0;
    always #5 i_Clk = ~i_Clk;

    int total = 0;
    int bad = 0;

    // Picture of the current frame.
    logic f_ball, f_pl, f_pr;
    int   f_bx, f_by, f_bw, f_bh, f_ply, f_pry;

    // Reference state.
    int   m_state;
    int   m_cnt;
    logic m_hdir, m_vdir, m_sl, m_sr;

    task automatic chk1(input string tag, input logic obs, input logic want);
        total++;
        assert (obs === want) else begin
            bad++;
            $error("FAIL %s: got %b want %b", tag, obs, want);
        end
    endtask

    task automatic chkn(input string tag, input int obs, input int want);
        total++;
        assert (obs === want) else begin
            bad++;
            $error("FAIL %s: got %0d want %0d", tag, obs, want);
        end
    endtask

    function automatic logic ball_at(input int x, input int y);
        return f_ball && x >= f_bx && x < f_bx + f_bw && y >= f_by && y < f_by + f_bh;
    endfunction

    // Paddles are 2 columns wide and 2 lines tall, at the left and right borders.
    function automatic logic padl_at(input int x, input int y);
        return f_pl && x <= 1 && y >= f_ply && y < f_ply + 2;
    endfunction

    function automatic logic padr_at(input int x, input int y);
        return f_pr && x >= HV - 2 && y >= f_pry && y < f_pry + 2;
    endfunction

    task automatic pic(input logic b, input int bx, input int by, input int bw, input int bh,
                       input logic pl, input int ply, input logic pr, input int pry);
        f_ball = b; f_bx = bx; f_by = by; f_bw = bw; f_bh = bh;
        f_pl = pl; f_ply = ply; f_pr = pr; f_pry = pry;
    endtask

    task automatic model_reset();
        m_state = S_SERVE; m_cnt = 0; m_hdir = 1'b0; m_vdir = 1'b0;
        m_sl = 1'b0; m_sr = 1'b0;
    endtask

    // Frame-end decision taken from what the picture shows.
    task automatic model_frame_end();
        logic hl, hr, el, er, et, eb, ml, mr;
        hl = 0; hr = 0; el = 0; er = 0; et = 0; eb = 0;
        for (int y = 0; y < VV; y++)
            for (int x = 0; x < HV; x++)
                if (ball_at(x, y)) begin
                    if (padl_at(x, y)) hl = 1;
                    if (padr_at(x, y)) hr = 1;
                    if (x == 0)        el = 1;
                    if (x == HV - 1)   er = 1;
                    if (y == 0)        et = 1;
                    if (y == VV - 1)   eb = 1;
                end
        m_sl = 1'b0; m_sr = 1'b0;
        if (m_state == S_SERVE) begin
            m_state = S_PLAY;
        end else if (m_state == S_MISS) begin
            if (m_cnt == 1) m_state = S_SERVE;
            else m_cnt = m_cnt - 1;
        end else begin
            ml = el && !hl;
            mr = er && !hr;
            if (hl != hr) m_hdir = hr;
            if (et != eb) m_vdir = eb;
            if (ml && !mr) begin
                m_sr = 1'b1; m_hdir = 1'b0; m_state = S_MISS; m_cnt = MISS_FRAMES;
            end else if (mr && !ml) begin
                m_sl = 1'b1; m_hdir = 1'b1; m_state = S_MISS; m_cnt = MISS_FRAMES;
            end
        end
    endtask

    // Plays one raster frame of the current picture. Blanking pixels carry random junk.
    // rst_end asserts i_Reset on the frame-end pixel. frz reports o_Freeze mid-frame.
    task automatic run_frame(input logic rst_end, output logic frz);
        frz = 1'b0;
        for (int y = 0; y < VT; y++) begin
            for (int x = 0; x < HT; x++) begin
                i_HBlank = (x >= HV);
                i_VBlank = (y >= VV);
                i_HReset = (x == HT - 1);
                i_VReset = (y == VT - 1);
                i_Reset  = rst_end && x == HT - 1 && y == VT - 1;
                if (x < HV && y < VV) begin
                    i_Ball = ball_at(x, y); i_PaddleL = padl_at(x, y); i_PaddleR = padr_at(x, y);
                end else begin
                    i_Ball = ($urandom & 1) != 0;
                    i_PaddleL = ($urandom & 1) != 0;
                    i_PaddleR = ($urandom & 1) != 0;
                end
                @(posedge i_Clk);
                #1;
                if (x == 0 && y == 0) begin
                    chk1("score_l_pulse_end", o_ScoreL, 1'b0);
                    chk1("score_r_pulse_end", o_ScoreR, 1'b0);
                end
                if (x == 2 && y == 1) begin
                    frz = o_Freeze;
                    chk1("freeze_mid", o_Freeze, m_state == S_MISS);
                end
            end
        end
        i_Reset = 1'b0;
        if (rst_end) model_reset();
        else model_frame_end();
        chk1("hdir", o_HDir, m_hdir);
        chk1("vdir", o_VDir, m_vdir);
        chk1("score_l", o_ScoreL, m_sl);
        chk1("score_r", o_ScoreR, m_sr);
        chk1("freeze", o_Freeze, m_state == S_MISS);
    endtask

    initial begin
        logic frz;
        int   nfrz;
        i_Reset = 1'b1; i_HBlank = 1'b1; i_VBlank = 1'b1; i_HReset = 1'b0; i_VReset = 1'b0;
        i_Ball = 1'b0; i_PaddleL = 1'b0; i_PaddleR = 1'b0;
        repeat (3) @(posedge i_Clk);
        #1;
        chk1("rst_hdir", o_HDir, 1'b0);
        chk1("rst_vdir", o_VDir, 1'b0);
        chk1("rst_score_l", o_ScoreL, 1'b0);
        chk1("rst_score_r", o_ScoreR, 1'b0);
        chk1("rst_freeze", o_Freeze, 1'b0);
        i_Reset = 1'b0;
        model_reset();

        // The serve frame ignores a ball on the left edge, then an empty play frame follows.
        pic(1, 0, 1, 1, 1, 0, 0, 0, 0);
        run_frame(1'b0, frz);
        pic(0, 0, 0, 1, 1, 0, 0, 0, 0);
        run_frame(1'b0, frz);

        // A right paddle hit on the right edge turns the ball left.
        pic(1, HV - 1, 1, 1, 1, 0, 0, 1, 1);
        run_frame(1'b0, frz);
        // A left paddle hit away from the edge turns the ball right, with no score.
        pic(1, 1, 2, 1, 1, 1, 2, 0, 0);
        run_frame(1'b0, frz);
        pic(1, HV - 1, 1, 1, 1, 0, 0, 1, 1);
        run_frame(1'b0, frz);

        // A left edge miss, then a frozen period while right paddle hits keep being shown.
        pic(1, 0, 2, 1, 1, 0, 0, 0, 0);
        run_frame(1'b0, frz);
        pic(1, HV - 1, 1, 1, 1, 0, 0, 1, 1);
        nfrz = 0;
        for (int k = 0; k < 80; k++) begin
            run_frame(1'b0, frz);
            if (!frz) break;
            nfrz++;
        end
        chkn("miss_frames", nfrz, MISS_FRAMES);
        run_frame(1'b0, frz);
        chk1("play_after_serve", o_HDir, 1'b1);

        // Vertical bounces off the bottom line, then off the top line.
        pic(1, 2, VV - 1, 1, 1, 0, 0, 0, 0);
        run_frame(1'b0, frz);
        pic(1, 2, 0, 1, 1, 0, 0, 0, 0);
        run_frame(1'b0, frz);

        // The left edge touched together with the left paddle is a save.
        pic(1, HV - 1, 1, 1, 1, 0, 0, 1, 1);
        run_frame(1'b0, frz);
        pic(1, 0, 1, 1, 1, 1, 1, 0, 0);
        run_frame(1'b0, frz);

        // Reset lands on the frame-end pixel of a miss frame.
        pic(1, 0, 1, 1, 1, 0, 0, 0, 0);
        run_frame(1'b1, frz);
        run_frame(1'b0, frz);
        run_frame(1'b0, frz);

        // Random pictures.
        for (int n = 0; n < 30; n++) begin
            pic(($urandom % 4) != 0, int'($urandom_range(HV - 1, 0)), int'($urandom_range(VV - 1, 0)),
                int'($urandom_range(2, 1)), int'($urandom_range(2, 1)),
                ($urandom & 1) != 0, int'($urandom_range(VV - 2, 0)),
                ($urandom & 1) != 0, int'($urandom_range(VV - 2, 0)));
            run_frame(1'b0, frz);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
